// File: rtl/sdram_resp_pkg.sv
// Shared constants for the SDRAM device responder: command codes, burst
// length decode and error flag positions.
package sdram_resp_pkg;

  // Command codes over {cs_n, ras_n, cas_n, we_n}, valid only while cke=1.
  localparam logic [3:0] CMD_LMR    = 4'b0000;
  localparam logic [3:0] CMD_AREF   = 4'b0001;
  localparam logic [3:0] CMD_PRE    = 4'b0010;
  localparam logic [3:0] CMD_ACTIVE = 4'b0011;
  localparam logic [3:0] CMD_WRITE  = 4'b0100;
  localparam logic [3:0] CMD_READ   = 4'b0101;
  localparam logic [3:0] CMD_BST    = 4'b0110;

  localparam logic [9:0] BL_1     = 10'd1;
  localparam logic [9:0] BL_2     = 10'd2;
  localparam logic [9:0] BL_4     = 10'd4;
  localparam logic [9:0] BL_8     = 10'd8;
  localparam logic [9:0] PAGE_LEN = 10'd512;

  localparam int ERR_BANK = 0;
  localparam int ERR_INIT = 1;
  localparam int ERR_OPEN = 2;
  localparam int ERR_MODE = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_BURST,
    ST_RD_BURST
  } burst_st_e;

  // Returns 0 for the reserved codes 100..110.
  function automatic logic [9:0] bl_decode(input logic [2:0] code);
    case (code)
      3'b000:  return BL_1;
      3'b001:  return BL_2;
      3'b010:  return BL_4;
      3'b011:  return BL_8;
      3'b111:  return PAGE_LEN;
      default: return 10'd0;
    endcase
  endfunction

  function automatic logic cl_legal(input logic [2:0] cl);
    return (cl == 3'd2) || (cl == 3'd3);
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Simple dual-port backing store: one write port, one registered read port.
// A same-cycle read and write of one address returns the old word.
module sdram_resp_mem #(
  parameter int DATA_W = 16,
  parameter int AW     = 12
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**AW];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/sdram_resp.sv
// SDRAM device-side responder: command decode, bank table, burst engine,
// CAS-latency read delay line and sticky protocol error flags.
//
// state       | meaning
// ST_IDLE     | no burst in flight; only a new READ/WRITE issues a column
// ST_WR_BURST | issuing remaining write columns, dq_in captured each cycle
// ST_RD_BURST | issuing remaining read columns into the delay line
module sdram_resp
  import sdram_resp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_cke,
  input  logic              sdram_cs_n,
  input  logic              sdram_ras_n,
  input  logic              sdram_cas_n,
  input  logic              sdram_we_n,
  input  logic [1:0]        sdram_ba,
  input  logic [12:0]       sdram_addr,
  input  logic [DATA_W-1:0] dq_in,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe,
  output logic              init_done,
  output logic [12:0]       mode_reg,
  output logic [15:0]       refresh_cnt,
  output logic [3:0]        err
);

  logic [3:0] cmd;
  logic       cmd_v, is_act, is_rd, is_wr, is_bst, is_pre, is_aref, is_lmr;
  assign cmd     = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  assign cmd_v   = sdram_cke & ~sdram_cs_n;
  assign is_act  = cmd_v && (cmd == CMD_ACTIVE);
  assign is_rd   = cmd_v && (cmd == CMD_READ);
  assign is_wr   = cmd_v && (cmd == CMD_WRITE);
  assign is_bst  = cmd_v && (cmd == CMD_BST);
  assign is_pre  = cmd_v && (cmd == CMD_PRE);
  assign is_aref = cmd_v && (cmd == CMD_AREF);
  assign is_lmr  = cmd_v && (cmd == CMD_LMR);

  burst_st_e   st_q;
  logic [1:0]  bba_q;
  logic [12:0] brow_q;
  logic [8:0]  bcol_q;
  logic [9:0]  rem_q;
  logic [3:0]  open_q;
  logic [12:0] row_q [4];
  logic        init_done_q, pre_all_q;
  logic [1:0]  aref_cnt_q;
  logic [12:0] mode_q;
  logic [15:0] ref_q;
  logic [3:0]  err_q;

  // Reserved BL codes fall back to single-beat bursts; mask keeps the wrap
  // inside the aligned block (0x1FF for page mode).
  logic [9:0] bl_raw, bl_eff;
  logic [8:0] col_mask;
  logic       cl3;
  assign bl_raw   = bl_decode(mode_q[2:0]);
  assign bl_eff   = (bl_raw == 10'd0) ? BL_1 : bl_raw;
  assign col_mask = 9'(bl_eff - 10'd1);
  assign cl3      = (mode_q[6:4] != 3'd2);

  function automatic logic [8:0] col_next(input logic [8:0] c, input logic [8:0] m);
    return (c & ~m) | ((c + 9'd1) & m);
  endfunction

  logic rw_cmd, brk, bank_open, e_bank, e_init, e_open, e_mode, rw_ok, act_ok;
  assign rw_cmd    = is_rd | is_wr;
  assign brk       = is_bst | is_pre | rw_cmd;
  assign bank_open = open_q[sdram_ba];
  assign e_init    = (is_act | rw_cmd) & ~init_done_q;
  assign e_bank    = init_done_q & ((rw_cmd & ~bank_open) | (is_act & bank_open));
  assign e_open    = (is_aref | is_lmr) & (|open_q);
  assign e_mode    = is_lmr & (~cl_legal(sdram_addr[6:4]) | (bl_decode(sdram_addr[2:0]) == 10'd0));
  assign rw_ok     = rw_cmd & ~e_init & ~e_bank;
  assign act_ok    = is_act & ~e_init & ~e_bank;

  logic        iss_wr, iss_rd;
  logic [1:0]  iss_ba;
  logic [12:0] iss_row;
  logic [8:0]  iss_col;
  always_comb begin
    iss_wr  = 1'b0;
    iss_rd  = 1'b0;
    iss_ba  = sdram_ba;
    iss_row = row_q[sdram_ba];
    iss_col = sdram_addr[8:0];
    if (rw_ok) begin
      iss_wr = is_wr;
      iss_rd = is_rd;
    end else if (st_q != ST_IDLE && !brk) begin
      iss_ba  = bba_q;
      iss_row = brow_q;
      iss_col = bcol_q;
      iss_wr  = (st_q == ST_WR_BURST);
      iss_rd  = (st_q == ST_RD_BURST);
    end
  end

  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  assign mem_addr = MEM_AW'({iss_ba, iss_row, iss_col});

  sdram_resp_mem #(.DATA_W(DATA_W), .AW(MEM_AW)) u_mem (
    .clk       (clk),
    .wr_en_i   (iss_wr),
    .wr_addr_i (mem_addr),
    .wr_data_i (dq_in),
    .rd_en_i   (iss_rd),
    .rd_addr_i (mem_addr),
    .rd_data_o (mem_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= ST_IDLE;
      bba_q       <= '0;
      brow_q      <= '0;
      bcol_q      <= '0;
      rem_q       <= '0;
      open_q      <= '0;
      for (int i = 0; i < 4; i++) row_q[i] <= '0;
      init_done_q <= 1'b0;
      pre_all_q   <= 1'b0;
      aref_cnt_q  <= '0;
      mode_q      <= '0;
      ref_q       <= '0;
      err_q       <= '0;
    end else begin
      if (rw_ok) begin
        bba_q  <= sdram_ba;
        brow_q <= row_q[sdram_ba];
        bcol_q <= col_next(sdram_addr[8:0], col_mask);
        rem_q  <= bl_eff - 10'd1;
        if (bl_eff == BL_1) st_q <= ST_IDLE;
        else                st_q <= is_wr ? ST_WR_BURST : ST_RD_BURST;
      end else if (brk) begin
        st_q <= ST_IDLE;
      end else if (st_q != ST_IDLE) begin
        bcol_q <= col_next(bcol_q, col_mask);
        rem_q  <= rem_q - 10'd1;
        if (rem_q == 10'd1) st_q <= ST_IDLE;
      end

      if (act_ok) begin
        open_q[sdram_ba] <= 1'b1;
        row_q[sdram_ba]  <= sdram_addr;
      end
      if (is_pre) begin
        if (sdram_addr[10]) begin
          open_q    <= '0;
          pre_all_q <= 1'b1;
        end else begin
          open_q[sdram_ba] <= 1'b0;
        end
      end

      if (is_aref) begin
        if (aref_cnt_q != 2'd2) aref_cnt_q <= aref_cnt_q + 2'd1;
        if (ref_q != 16'hFFFF)  ref_q <= ref_q + 16'd1;
      end
      if (is_lmr) begin
        mode_q <= sdram_addr;
        if (pre_all_q && aref_cnt_q == 2'd2) init_done_q <= 1'b1;
      end

      err_q[ERR_BANK] <= err_q[ERR_BANK] | e_bank;
      err_q[ERR_INIT] <= err_q[ERR_INIT] | e_init;
      err_q[ERR_OPEN] <= err_q[ERR_OPEN] | e_open;
      err_q[ERR_MODE] <= err_q[ERR_MODE] | e_mode;
    end
  end

  // Read delay line: memory register, one middle stage, output register.
  // CL=2 bypasses the middle stage.
  logic              rd_v0_q, mid_v_q, oe_q, out_v;
  logic [DATA_W-1:0] mid_d_q, dq_q, out_d;
  assign out_v = cl3 ? mid_v_q : rd_v0_q;
  assign out_d = cl3 ? mid_d_q : mem_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v0_q <= 1'b0;
      mid_v_q <= 1'b0;
      mid_d_q <= '0;
      oe_q    <= 1'b0;
      dq_q    <= '0;
    end else if (is_wr) begin
      rd_v0_q <= 1'b0;
      mid_v_q <= 1'b0;
      oe_q    <= 1'b0;
      dq_q    <= '0;
    end else begin
      rd_v0_q <= iss_rd;
      mid_v_q <= rd_v0_q;
      mid_d_q <= mem_rd_data;
      oe_q    <= out_v;
      dq_q    <= out_v ? out_d : '0;
    end
  end

  assign dq_out      = dq_q;
  assign dq_oe       = oe_q;
  assign init_done   = init_done_q;
  assign mode_reg    = mode_q;
  assign refresh_cnt = ref_q;
  assign err         = err_q;

endmodule

// File: tb/tb_sdram_resp.sv
// Scoreboard bench for sdram_resp: read data expected per cycle is queued when
// the READ is driven and checked against dq_out/dq_oe as it emerges.
module tb_sdram_resp;

  localparam logic [3:0] C_LMR  = 4'b0000;
  localparam logic [3:0] C_AREF = 4'b0001;
  localparam logic [3:0] C_PRE  = 4'b0010;
  localparam logic [3:0] C_ACT  = 4'b0011;
  localparam logic [3:0] C_WR   = 4'b0100;
  localparam logic [3:0] C_RD   = 4'b0101;
  localparam logic [3:0] C_BST  = 4'b0110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe, init_done;
  logic [12:0] mode_reg;
  logic [15:0] refresh_cnt;
  logic [3:0]  err;

  sdram_resp #(.DATA_W(16), .MEM_AW(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sdram_cke   (cke),
    .sdram_cs_n  (cs_n),
    .sdram_ras_n (ras_n),
    .sdram_cas_n (cas_n),
    .sdram_we_n  (we_n),
    .sdram_ba    (ba),
    .sdram_addr  (addr),
    .dq_in       (dq_in),
    .dq_out      (dq_out),
    .dq_oe       (dq_oe),
    .init_done   (init_done),
    .mode_reg    (mode_reg),
    .refresh_cnt (refresh_cnt),
    .err         (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [15:0] d;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: memory image, per-bank rows, burst length and CAS latency.
  logic [15:0] mm [4096];
  int bank_row [4];
  int bl_m = 1;
  int cl_m = 3;

  function automatic int nxt(input int c);
    int base;
    base = (c / bl_m) * bl_m;
    return base + ((c - base + 1) % bl_m);
  endfunction

  function automatic int mi(input int b, input int c);
    return ((bank_row[b] % 8) * 512) + c;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("rd_slot", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        check("dq_oe", {31'd0, dq_oe}, 32'd1);
        check("dq_out", {16'd0, dq_out}, {16'd0, e.d});
      end else if (dq_oe) begin
        check("dq_oe_idle", {31'd0, dq_oe}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    cke = 1'b1; cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    ba = 2'd0; addr = 13'd0;
  endtask

  task automatic drive(input logic [3:0] c, input int b, input int a);
    cke = 1'b1;
    {cs_n, ras_n, cas_n, we_n} = c;
    ba   = 2'(b);
    addr = 13'(a);
  endtask

  task automatic issue(input logic [3:0] c, input int b, input int a);
    drive(c, b, a);
    step();
    nop();
  endtask

  task automatic push(input int t, input logic [15:0] d);
    exp_t e;
    e.cyc = t;
    e.d   = d;
    exp_q.push_back(e);
  endtask

  task automatic wr_burst(input int b, input int c, input int n, input logic [15:0] base);
    int col;
    col = c;
    for (int i = 0; i < n; i++) begin
      if (i == 0) drive(C_WR, b, c);
      else        nop();
      dq_in = 16'(base + 16'(i));
      mm[mi(b, col)] = dq_in;
      col = nxt(col);
      step();
    end
    drive(C_BST, b, 0);
    dq_in = 16'hDEAD;
    step();
    nop();
    dq_in = 16'h0;
  endtask

  task automatic rd_burst(input int b, input int c, input int n);
    int col, t;
    col = c;
    t   = cyc;
    for (int i = 0; i < n; i++) begin
      if (i == 0) drive(C_RD, b, c);
      else        nop();
      push(t + cl_m + i, mm[mi(b, col)]);
      col = nxt(col);
      step();
    end
    drive(C_BST, b, 0);
    step();
    nop();
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() > 0; i++) step();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_async_err", {28'd0, err}, 32'd0);
    check("rst_async_oe", {31'd0, dq_oe}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int t;
    nop();
    dq_in = 16'h0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    check("rst_dq_out", {16'd0, dq_out}, 32'd0);
    check("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_mode_reg", {19'd0, mode_reg}, 32'd0);
    check("rst_refresh", {16'd0, refresh_cnt}, 32'd0);
    check("rst_err", {28'd0, err}, 32'd0);

    issue(C_RD, 0, 0);
    check("err_rd_pre_init", {28'd0, err}, 32'h2);
    for (int i = 0; i < 6; i++) step();
    check("oe_rd_pre_init", {31'd0, dq_oe}, 32'd0);
    do_reset();

    issue(C_PRE, 0, 16'h1FFF);
    for (int i = 0; i < 8; i++) issue(C_AREF, 0, 0);
    check("init_before_lmr", {31'd0, init_done}, 32'd0);
    issue(C_LMR, 0, 16'h037);
    bl_m = 512;
    cl_m = 3;
    check("init_done", {31'd0, init_done}, 32'd1);
    check("init_mode", {19'd0, mode_reg}, 32'h037);
    check("init_refresh", {16'd0, refresh_cnt}, 32'd8);
    check("init_err", {28'd0, err}, 32'd0);

    issue(C_ACT, 1, 5);
    bank_row[1] = 5;
    wr_burst(1, 4, 4, 16'h4400);
    wr_burst(1, 0, 4, 16'h1000);
    rd_burst(1, 0, 4);
    drain();
    rd_burst(1, 4, 1);
    drain();

    // Seamless READ two cycles into a burst.
    t = cyc;
    drive(C_RD, 1, 0);
    push(t + 3, mm[mi(1, 0)]);
    push(t + 4, mm[mi(1, 1)]);
    step();
    nop();
    step();
    drive(C_RD, 1, 4);
    push(t + 5, mm[mi(1, 4)]);
    push(t + 6, mm[mi(1, 5)]);
    step();
    nop();
    step();
    drive(C_BST, 1, 0);
    step();
    nop();
    drain();

    wr_burst(1, 16'h1FF, 2, 16'hA000);
    rd_burst(1, 16'h1FF, 2);
    drain();
    rd_burst(1, 0, 1);
    drain();

    issue(C_PRE, 0, 16'h400);
    issue(C_LMR, 0, 16'h027);
    cl_m = 2;
    check("cl2_mode", {19'd0, mode_reg}, 32'h027);
    check("cl2_err", {28'd0, err}, 32'd0);
    issue(C_ACT, 1, 5);
    rd_burst(1, 0, 4);
    drain();

    // WRITE during a read burst: only the first beat emerges.
    t = cyc;
    drive(C_RD, 1, 0);
    push(t + 2, mm[mi(1, 0)]);
    step();
    nop();
    step();
    drive(C_WR, 1, 16'h10);
    dq_in = 16'h5555;
    mm[mi(1, 16'h10)] = 16'h5555;
    step();
    drive(C_BST, 1, 0);
    dq_in = 16'h0;
    step();
    nop();
    for (int i = 0; i < 4; i++) step();
    drain();
    rd_burst(1, 16'h10, 1);
    drain();

    issue(C_RD, 2, 0);
    check("err_closed_bank", {28'd0, err}, 32'h1);
    for (int i = 0; i < 5; i++) step();
    issue(C_AREF, 0, 0);
    check("err_aref_open", {28'd0, err}, 32'h5);
    check("refresh_9", {16'd0, refresh_cnt}, 32'd9);
    issue(C_LMR, 0, 16'h044);
    check("err_mode", {28'd0, err}, 32'hD);
    check("mode_illegal_loads", {19'd0, mode_reg}, 32'h044);
    for (int i = 0; i < 4; i++) step();
    check("err_sticky", {28'd0, err}, 32'hD);
    do_reset();
    check("final_err", {28'd0, err}, 32'd0);
    check("final_init", {31'd0, init_done}, 32'd0);
    check("final_refresh", {16'd0, refresh_cnt}, 32'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
